// File: rtl/uart_fifo_bridge.sv
// uart_fifo_bridge: TX/RX FIFO buffer between the CPU uart slot and a byte-stream UART core, with loopback, counters and sticky errors
module uart_fifo_bridge #(
    parameter int WIDTH       = 8,
    parameter int TX_DEPTH    = 16,
    parameter int RX_DEPTH    = 16,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   _mr,
    input  logic                   _wr,
    input  logic                   _rd,
    input  logic [WIDTH-1:0]       cpu_din,
    output logic [WIDTH-1:0]       cpu_dout,
    output logic                   flag_di,
    output logic                   flag_do,
    input  logic                   loopback,
    output logic [WIDTH-1:0]       ser_tx_data,
    output logic                   ser_tx_valid,
    input  logic                   ser_tx_ready,
    input  logic [WIDTH-1:0]       ser_rx_data,
    input  logic                   ser_rx_valid,
    output logic                   ser_rx_ready,
    output logic [COUNT_WIDTH-1:0] tx_count,
    output logic [COUNT_WIDTH-1:0] rx_count,
    output logic                   tx_overflow,
    output logic                   rx_underrun,
    input  logic                   clear_err
);
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);

    logic [WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [WIDTH-1:0] rx_mem [RX_DEPTH];
    logic [TA:0]      tx_wp, tx_rp;
    logic [RA:0]      rx_wp, rx_rp;
    logic             loop_q;
    logic             tx_empty, tx_full, rx_empty, rx_full;
    logic             tx_push, tx_pop, rx_push, rx_pop;
    logic [WIDTH-1:0] tx_head, rx_head, rx_in;

    // Full when the pointers differ only in the wrap bit, so all DEPTH slots are usable
    always_comb begin
        tx_empty     = tx_wp == tx_rp;
        tx_full      = (tx_wp[TA] != tx_rp[TA]) && (tx_wp[TA-1:0] == tx_rp[TA-1:0]);
        rx_empty     = rx_wp == rx_rp;
        rx_full      = (rx_wp[RA] != rx_rp[RA]) && (rx_wp[RA-1:0] == rx_rp[RA-1:0]);
        tx_head      = tx_mem[tx_rp[TA-1:0]];
        rx_head      = rx_mem[rx_rp[RA-1:0]];
        tx_push      = !_wr && !tx_full;
        rx_pop       = !_rd && !rx_empty;
        tx_pop       = !tx_empty && (loop_q ? !rx_full : ser_tx_ready);
        rx_push      = loop_q ? tx_pop : (ser_rx_valid && !rx_full);
        rx_in        = loop_q ? tx_head : ser_rx_data;
        cpu_dout     = rx_empty ? '0 : rx_head;
        flag_di      = !rx_empty;
        flag_do      = !tx_full;
        ser_tx_data  = tx_head;
        ser_tx_valid = !loop_q && !tx_empty;
        ser_rx_ready = !loop_q && !rx_full;
    end

    always_ff @(posedge clk or negedge _mr) begin
        if (!_mr) begin
            tx_wp       <= '0;
            tx_rp       <= '0;
            rx_wp       <= '0;
            rx_rp       <= '0;
            loop_q      <= 1'b0;
            tx_count    <= '0;
            rx_count    <= '0;
            tx_overflow <= 1'b0;
            rx_underrun <= 1'b0;
        end else begin
            loop_q      <= loopback;
            tx_wp       <= tx_wp + {{TA{1'b0}}, tx_push};
            tx_rp       <= tx_rp + {{TA{1'b0}}, tx_pop};
            rx_wp       <= rx_wp + {{RA{1'b0}}, rx_push};
            rx_rp       <= rx_rp + {{RA{1'b0}}, rx_pop};
            tx_count    <= tx_count + {{(COUNT_WIDTH-1){1'b0}}, tx_pop};
            rx_count    <= rx_count + {{(COUNT_WIDTH-1){1'b0}}, rx_push};
            tx_overflow <= (!_wr && tx_full) || (tx_overflow && !clear_err);
            rx_underrun <= (!_rd && rx_empty) || (rx_underrun && !clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[TA-1:0]] <= cpu_din;
        if (rx_push) rx_mem[rx_wp[RA-1:0]] <= rx_in;
    end
endmodule

// File: tb/tb_uart_fifo_bridge.sv
// tb_uart_fifo_bridge: directed plan plus random traffic, checked each cycle against a queue-based model
module tb_uart_fifo_bridge;
    logic        clk = 0, mr_n, wr_n, rd_n, loopback, clear_err;
    logic        ser_tx_ready, ser_rx_valid;
    logic [7:0]  cpu_din, ser_rx_data;
    logic [7:0]  cpu_dout, ser_tx_data, w_cpu_dout, w_ser_tx_data;
    logic        flag_di, flag_do, ser_tx_valid, ser_rx_ready, tx_overflow, rx_underrun;
    logic        w_flag_di, w_flag_do, w_ser_tx_valid, w_ser_rx_ready, w_tx_overflow, w_rx_underrun;
    logic [15:0] tx_count, rx_count;
    logic [3:0]  w_tx_count, w_rx_count;
    int          errors = 0, checks = 0;

    uart_fifo_bridge dut (
        .clk(clk), ._mr(mr_n), ._wr(wr_n), ._rd(rd_n), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .flag_di(flag_di), .flag_do(flag_do), .loopback(loopback), .ser_tx_data(ser_tx_data),
        .ser_tx_valid(ser_tx_valid), .ser_tx_ready(ser_tx_ready), .ser_rx_data(ser_rx_data),
        .ser_rx_valid(ser_rx_valid), .ser_rx_ready(ser_rx_ready), .tx_count(tx_count),
        .rx_count(rx_count), .tx_overflow(tx_overflow), .rx_underrun(rx_underrun), .clear_err(clear_err)
    );

    // Narrow-counter twin driven by the same stimulus, to exercise counter wrap
    uart_fifo_bridge #(.COUNT_WIDTH(4)) w_dut (
        .clk(clk), ._mr(mr_n), ._wr(wr_n), ._rd(rd_n), .cpu_din(cpu_din), .cpu_dout(w_cpu_dout),
        .flag_di(w_flag_di), .flag_do(w_flag_do), .loopback(loopback), .ser_tx_data(w_ser_tx_data),
        .ser_tx_valid(w_ser_tx_valid), .ser_tx_ready(ser_tx_ready), .ser_rx_data(ser_rx_data),
        .ser_rx_valid(ser_rx_valid), .ser_rx_ready(w_ser_rx_ready), .tx_count(w_tx_count),
        .rx_count(w_rx_count), .tx_overflow(w_tx_overflow), .rx_underrun(w_rx_underrun), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: two bounded queues, plain counters
    logic [7:0] txq[$], rxq[$];
    logic       m_loop = 0, m_ovf = 0, m_unr = 0;
    int         m_txc = 0, m_rxc = 0;

    always @(posedge clk or negedge mr_n) begin
        logic tf, rf, te, re, mtx, mrx;
        logic [7:0] d;
        if (!mr_n) begin
            txq.delete();
            rxq.delete();
            m_loop <= 0; m_ovf <= 0; m_unr <= 0; m_txc <= 0; m_rxc <= 0;
        end else begin
            tf = txq.size() == 16; rf = rxq.size() == 16;
            te = txq.size() == 0;  re = rxq.size() == 0;
            mtx = !te && (m_loop ? !rf : ser_tx_ready);
            mrx = m_loop ? mtx : (ser_rx_valid && !rf);
            d = m_loop ? (te ? 8'h00 : txq[0]) : ser_rx_data;
            m_ovf <= (!wr_n && tf) || (m_ovf && !clear_err);
            m_unr <= (!rd_n && re) || (m_unr && !clear_err);
            m_txc <= m_txc + int'(mtx);
            m_rxc <= m_rxc + int'(mrx);
            m_loop <= loopback;
            if (mtx) void'(txq.pop_front());
            if (!wr_n && !tf) txq.push_back(cpu_din);
            if (!rd_n && !re) void'(rxq.pop_front());
            if (mrx) rxq.push_back(d);
        end
    end

    always @(negedge clk) begin
        logic       e_di, e_do, e_tv, e_rr;
        logic [7:0] e_dout;
        e_di = rxq.size() != 0;
        e_do = txq.size() != 16;
        e_dout = e_di ? rxq[0] : 8'h00;
        e_tv = !m_loop && txq.size() != 0;
        e_rr = !m_loop && rxq.size() != 16;
        chk("flag_di", flag_di, e_di);
        chk("flag_do", flag_do, e_do);
        chk("cpu_dout", cpu_dout, e_dout);
        chk("ser_tx_valid", ser_tx_valid, e_tv);
        chk("ser_rx_ready", ser_rx_ready, e_rr);
        chk("tx_count", tx_count, m_txc & 16'hFFFF);
        chk("rx_count", rx_count, m_rxc & 16'hFFFF);
        chk("tx_overflow", tx_overflow, m_ovf);
        chk("rx_underrun", rx_underrun, m_unr);
        if (e_tv) chk("ser_tx_data", ser_tx_data, txq[0]);
        chk("w_tx_count", w_tx_count, m_txc % 16);
        chk("w_rx_count", w_rx_count, m_rxc % 16);
        chk("w_cpu_dout", w_cpu_dout, e_dout);
        chk("w_flags", {w_flag_di, w_flag_do, w_ser_tx_valid, w_ser_rx_ready, w_tx_overflow, w_rx_underrun},
            {e_di, e_do, e_tv, e_rr, m_ovf, m_unr});
        if (e_tv) chk("w_ser_tx_data", w_ser_tx_data, txq[0]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_n = 1; rd_n = 1; clear_err = 0; ser_rx_valid = 0; ser_tx_ready = 0;
    endtask

    initial begin
        int n;
        logic acc;
        mr_n = 0; loopback = 0; cpu_din = 0; ser_rx_data = 0;
        idle();
        tick(); tick();
        chk("rst_outputs", {flag_di, flag_do, cpu_dout, ser_tx_valid, ser_rx_ready}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b1});
        chk("rst_counts", {tx_count, rx_count, tx_overflow, rx_underrun}, 34'h0);
        mr_n = 1;
        tick();

        // External TX: fill, overflow, drain in order
        for (int i = 1; i <= 16; i++) begin
            cpu_din = 8'(i); wr_n = 0; tick();
        end
        chk("tx_full_flag_do", flag_do, 1'b0);
        cpu_din = 8'hAA; tick(); wr_n = 1;
        chk("tx_overflow_set", tx_overflow, 1'b1);
        ser_tx_ready = 1;
        for (int i = 1; i <= 16; i++) begin
            chk("tx_drain_valid", ser_tx_valid, 1'b1);
            chk("tx_drain_data", ser_tx_data, 8'(i));
            tick();
        end
        ser_tx_ready = 0;
        chk("tx_count_16", tx_count, 16'd16);
        chk("tx_empty_valid", ser_tx_valid, 1'b0);
        clear_err = 1; tick(); clear_err = 0;
        chk("tx_overflow_clr", tx_overflow, 1'b0);

        // External RX: fill to full, hold the 17th, read all in order
        ser_rx_valid = 1; n = 0;
        for (int c = 0; c < 40 && n < 16; c++) begin
            ser_rx_data = 8'h30 + 8'(n); acc = ser_rx_ready; tick();
            if (acc) n++;
        end
        ser_rx_data = 8'h40;
        tick(); tick();
        chk("rx_full_ready", ser_rx_ready, 1'b0);
        chk("rx_count_16", rx_count, 16'd16);
        for (int i = 0; i < 17; i++) begin
            chk("rx_read_data", cpu_dout, 8'h30 + 8'(i));
            acc = ser_rx_ready && ser_rx_valid; rd_n = 0; tick();
            if (acc) ser_rx_valid = 0;
        end
        rd_n = 1;
        chk("rx_count_17", rx_count, 16'd17);
        chk("rx_drained_di", flag_di, 1'b0);
        chk("no_underrun", rx_underrun, 1'b0);

        // Loopback latency
        loopback = 1; tick();
        cpu_din = 8'h5A; wr_n = 0; tick(); wr_n = 1;
        chk("loop_n_di", flag_di, 1'b0);
        chk("loop_tx_valid", ser_tx_valid, 1'b0);
        tick();
        chk("loop_n1_di", flag_di, 1'b1);
        chk("loop_n1_dout", cpu_dout, 8'h5A);
        rd_n = 0; tick(); rd_n = 1;
        loopback = 0; tick();

        // Underrun and clear priority
        rd_n = 0; tick(); rd_n = 1;
        chk("underrun_set", rx_underrun, 1'b1);
        clear_err = 1; tick();
        chk("underrun_clr", rx_underrun, 1'b0);
        rd_n = 0; tick(); rd_n = 1;
        chk("underrun_prio", rx_underrun, 1'b1);
        tick(); clear_err = 0;
        chk("underrun_clr2", rx_underrun, 1'b0);

        // Counter wrap: 20 words through the loop from a fresh reset
        mr_n = 0; tick(); mr_n = 1;
        loopback = 1; tick();
        for (int i = 0; i < 20; i++) begin
            cpu_din = 8'(i + 1); wr_n = 0; rd_n = 0; tick();
        end
        wr_n = 1;
        repeat (4) tick();
        rd_n = 1;
        chk("wrap_tx_count", w_tx_count, 4'd4);
        chk("wrap_rx_count", w_rx_count, 4'd4);
        chk("full_tx_count", tx_count, 16'd20);
        chk("full_rx_count", rx_count, 16'd20);

        // Asynchronous reset with 5 words queued each way
        loopback = 0; tick();
        for (int i = 0; i < 5; i++) begin
            cpu_din = 8'h80 + 8'(i); wr_n = 0;
            ser_rx_data = 8'h90 + 8'(i); ser_rx_valid = 1;
            tick();
        end
        idle();
        chk("pre_rst_di", flag_di, 1'b1);
        chk("pre_rst_tv", ser_tx_valid, 1'b1);
        #2 mr_n = 0;
        #1;
        chk("async_rst_outputs", {flag_di, flag_do, cpu_dout, ser_tx_valid, ser_rx_ready}, {1'b0, 1'b1, 8'h00, 1'b0, 1'b1});
        chk("async_rst_counts", {tx_count, rx_count}, 32'h0);
        tick(); mr_n = 1;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            wr_n = ($urandom_range(0, 99) < 40) ? 1'b0 : 1'b1;
            rd_n = ($urandom_range(0, 99) < 35) ? 1'b0 : 1'b1;
            cpu_din = 8'($urandom);
            ser_rx_data = 8'($urandom);
            ser_rx_valid = 1'($urandom);
            ser_tx_ready = ($urandom_range(0, 99) < 45);
            clear_err = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 4) loopback = ~loopback;
            mr_n = ($urandom_range(0, 999) < 2) ? 1'b0 : 1'b1;
            tick();
        end
        idle(); mr_n = 1;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_fifo_bridge.md
Name: uart_fifo_bridge

Overview:
- Parametrised UART-side buffer between the CPU `uart` device slot and an external byte-stream UART core.
- Provides independent TX and RX FIFOs of configurable width and depth.
- Drives the CPU condition flags DI (data in available) and DO (data out possible).
- Adds a runtime loopback mode, wrapping transfer counters and sticky error flags, none of which the single-register UART device has.

Parameters:
- WIDTH, 8, data word width in bits.
- TX_DEPTH, 16, TX FIFO entries; power of 2, minimum 2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, minimum 2.
- COUNT_WIDTH, 16, width of the transfer counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- _mr  in  1  master reset; asynchronous, active-low.
- _wr  in  1  CPU write strobe, active-low, sampled at rising edge.
- _rd  in  1  CPU read strobe, active-low, sampled at rising edge.
- cpu_din  in  WIDTH  word written into the TX FIFO.
- cpu_dout  out  WIDTH  RX FIFO head (first-word-fall-through); 0 when RX is empty.
- flag_di  out  1  RX FIFO not empty.
- flag_do  out  1  TX FIFO not full.
- loopback  in  1  mode request: 1 = internal TX->RX loop.
- ser_tx_data  out  WIDTH  TX FIFO head.
- ser_tx_valid  out  1  TX word offered to the external core.
- ser_tx_ready  in  1  external core accepts the TX word.
- ser_rx_data  in  WIDTH  inbound word.
- ser_rx_valid  in  1  inbound word offered.
- ser_rx_ready  out  1  bridge accepts the inbound word.
- tx_count  out  COUNT_WIDTH  words drained from TX.
- rx_count  out  COUNT_WIDTH  words pushed into RX.
- tx_overflow  out  1  sticky: CPU write while TX full.
- rx_underrun  out  1  sticky: CPU read while RX empty.
- clear_err  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (_mr low, asynchronous):
  - Both FIFOs emptied, counters = 0, sticky flags = 0, loop register = 0.
  - Outputs during reset: flag_di=0, flag_do=1, cpu_dout=0, ser_tx_valid=0, ser_rx_ready=1.
- Reset release is synchronous to clk. Reset asserted mid-transfer discards all buffered words; no partial handshake completes.
- Mode:
  - `loopback` is registered into loop_q at each edge; the new mode takes effect the cycle after it is sampled.
  - A mode switch never loses or duplicates a word.
- CPU write, edge with _wr=0:
  - TX not full (occupancy before the edge): cpu_din is pushed.
  - TX full: the word is dropped and tx_overflow is set. A same-cycle drain does not make room.
- CPU read, edge with _rd=0:
  - RX not empty: the head is popped and cpu_dout shows the next entry after the edge.
  - RX empty: no pop, and rx_underrun is set.
- Flags and data outputs are registered-state derived. A push at edge N is visible on flag_di/flag_do/cpu_dout/ser_tx_valid after edge N (1-cycle latency).
- External mode (loop_q=0):
  - ser_tx_valid = TX not empty; ser_tx_data = TX head.
  - A pop occurs on an edge with valid && ready. ser_tx_data stays stable until accepted.
  - ser_rx_ready = RX not full (pre-edge occupancy). A push occurs on an edge with ser_rx_valid && ser_rx_ready.
  - No inbound word is ever lost; back-pressure only.
- Loop mode (loop_q=1):
  - ser_tx_valid=0 and ser_rx_ready=0.
  - Each edge where TX is not empty and RX is not full moves exactly one word from the TX head to the RX tail.
  - CPU write at edge N appears on cpu_dout/flag_di after edge N+1.
- Simultaneous events:
  - CPU push and drain on TX in the same edge: both occur, occupancy unchanged.
  - CPU pop and inbound push on RX in the same edge: both occur. Exception: RX full means the push is refused, since ready was already 0.
  - RX empty with a read and a push in the same edge: underrun flagged, push accepted.
- Counters:
  - tx_count increments on every TX pop (external or loop).
  - rx_count increments on every RX push.
  - Both are modulo 2^COUNT_WIDTH; 2^COUNT_WIDTH-1 wraps to 0.
- clear_err=1 clears both sticky flags at the edge. A new error in the same edge takes priority and the flag stays set.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the wrap bit. Exactly DEPTH words are storable.

Test Plan:
- Reset then idle: all outputs at reset values. Assert _mr low mid-traffic with 5 words queued: FIFOs empty, counts 0 asynchronously.
- External TX: write 0x01..0x10 with ser_tx_ready=0. Flag_do drops after the 16th write. A 17th write (0xAA) sets tx_overflow and is not stored. Raise ready: 0x01..0x10 drain in order, tx_count=16.
- External RX: hold ser_rx_valid with 17 words, no CPU reads. ser_rx_ready=0 after 16 pushes and the 17th is held, not lost. Read all: order preserved, rx_count=17 after the held word enters.
- Loopback: loopback=1, write 0x5A at edge N. flag_di=1 and cpu_dout=0x5A after edge N+1; ser_tx_valid stays 0.
- Counter wrap: COUNT_WIDTH=4, loop 20 words. tx_count=rx_count=4.
- Underrun/clear: read with RX empty sets rx_underrun. clear_err alone clears it. clear_err plus an empty read in the same edge keeps it set.
